add_1: RTL and testbench

Bit-serial 1-bit adder with registered outputs and a carry held across clock cycles. Operands arrive LSB-first, one bit per cycle on `a` and `b`. The block produces one registered sum bit per cycle, and the carry is fed back into the next bit position. It is the arithmetic leaf used by serial datapaths that stream operands bit by bit.

---
 rtl/add_1_pkg.sv | 22 ++
 rtl/add_1_if.sv | 26 ++
 rtl/add_1_full_adder_cell.sv | 20 ++
 rtl/add_1.sv | 41 ++++
 tb/tb_add_1.sv | 122 ++++++++++++
 5 files changed

// File: rtl/add_1_pkg.sv
// add_1_pkg: shared constants for the bit-serial adder slice.
// Contents: reset polarity and the value the output registers take in reset.
// Imported by the interface, the full-adder cell and the add_1 top.
package add_1_pkg;

  // rstn is active-high despite its name: 1 means reset.
  localparam logic ADD_1_RST_ACTIVE = 1'b1;

  // Value loaded into both sum and cout while in reset.
  localparam logic ADD_1_RST_VAL    = 1'b0;

  // Single-bit full add. Returns {carry, sum}, so the result is the
  // 2-bit count of ones among the three inputs (0..3).
  function automatic logic [1:0] fa_eval(input logic a, input logic b, input logic cin);
    logic s;
    logic c;
    s = a ^ b ^ cin;
    c = (a & b) | (a & cin) | (b & cin);
    return {c, s};
  endfunction

endpackage

// File: rtl/add_1_if.sv
// add_1_if: operand/result bundle for the bit-serial adder.
// Signals: a, b (operand bits, LSB-first) and sum, cout (registered results).
// Modports: master drives operands and reads results; slave is the adder side.
interface add_1_if;
  import add_1_pkg::*;

  logic a;     // operand A bit for the current bit position
  logic b;     // operand B bit for the current bit position
  logic sum;   // registered sum bit of the previous cycle's addition
  logic cout;  // registered carry-out, also the next cycle's carry-in

  modport master (
    output a,
    output b,
    input  sum,
    input  cout
  );

  modport slave (
    input  a,
    input  b,
    output sum,
    output cout
  );

endinterface

// File: rtl/add_1_full_adder_cell.sv
// full_adder_cell: purely combinational 1-bit full adder.
// Ports: a, b, cin in; s (sum) and c (carry) out.
// No state; zero latency.
module full_adder_cell
  import add_1_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic [1:0] w_res;

  assign w_res = fa_eval(a, b, cin);
  assign s     = w_res[0];
  assign c     = w_res[1];

endmodule

// File: rtl/add_1.sv
// add_1: bit-serial adder; one operand bit pair per cycle, LSB-first.
// Ports: clk, rstn (synchronous, 1 = reset), bus.slave carries a/b in and sum/cout out.
// Latency 1 cycle; no backpressure, a new bit is consumed on every rising edge.
module add_1
  import add_1_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  add_1_if.slave   bus
);

  logic r_sum;
  logic r_cout;
  logic w_s;
  logic w_c;

  // The carry register doubles as cout and as the carry-in of the next bit.
  full_adder_cell u_cell (
    .a   (bus.a),
    .b   (bus.b),
    .cin (r_cout),
    .s   (w_s),
    .c   (w_c)
  );

  // Reset has priority over the operands: a new word is started by holding
  // rstn for at least one edge, which also discards any pending carry.
  always_ff @(posedge clk) begin
    if (rstn == ADD_1_RST_ACTIVE) begin
      r_sum  <= ADD_1_RST_VAL;
      r_cout <= ADD_1_RST_VAL;
    end else begin
      r_sum  <= w_s;
      r_cout <= w_c;
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_add_1.sv
// tb_add_1: directed vectors for the bit-serial adder with a queue scoreboard.
// Stimulus is applied on the falling edge; results are checked 1 time unit
// after the following rising edge by an independent monitor.
module tb_add_1;
  import add_1_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  bit   done;

  typedef struct {
    string name;
    logic  sum;
    logic  cout;
  } exp_t;

  exp_t exp_q[$];

  add_1_if bus ();

  add_1 dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one bit position and record the hand-computed result expected
  // after the next rising edge.
  task automatic step(input string name, input logic rst, input logic a, input logic b,
                      input logic e_sum, input logic e_cout);
    exp_t e;
    @(negedge clk);
    rstn  = rst;
    bus.a = a;
    bus.b = b;
    e.name = name;
    e.sum  = e_sum;
    e.cout = e_cout;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge produces one result bit pair.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.sum !== e.sum) begin
          errors++;
          $display("FAIL %s sum: got %b expected %b", e.name, bus.sum, e.sum);
        end
        checks++;
        if (bus.cout !== e.cout) begin
          errors++;
          $display("FAIL %s cout: got %b expected %b", e.name, bus.cout, e.cout);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    done   = 1'b0;
    rstn   = 1'b1;
    bus.a  = 1'b0;
    bus.b  = 1'b0;

    // Reset holds outputs at 0 even with both operands high.
    step("reset0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("reset1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Zero add.
    step("zero0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("zero1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single ones, no carry.
    step("b_only0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("b_only1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("a_only0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("a_only1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Carry generate, then 1+1+1, then carry drains into the sum.
    step("gen",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("prop",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step("drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 0b1011 + 0b0110 = 17: sum bits 1,0,0,0 and final cout 1.
    step("word_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("word_b0",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("word_b1",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("word_b2",  1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("word_b3",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-word with cout=1: carry is discarded, inputs ignored.
    step("mid_rst",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("after_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Let the monitor drain the queue, bounded.
    @(negedge clk);
    rstn  = 1'b1;
    bus.a = 1'b0;
    bus.b = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
